piso_shift_ctrl: RTL
====================

Name: piso_shift_ctrl

Overview:
Parameterised parallel-in/serial-out shifter that generalises the 8-bit load/shift/inhibit register used on the embedded board.
- Adds configurable width, selectable bit order and a bit counter.
- Adds a valid/ready load handshake, synchronous flush and a frame-done pulse.
- Sits between a CPU/bus-side word source and a serial pin or downstream cascade; ser_in chains devices.

Parameters:
WIDTH, 8, shift register width in bits (>=2)
LSB_FIRST, 1, 1 = bit 0 shifted out first; 0 = bit WIDTH-1 first
CNT_W, $clog2(WIDTH+1), localparam, bit counter width (not overridable)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
ld_data  in  WIDTH  parallel word to load
ld_valid  in  1  load request
ld_ready  out  1  block accepts ld_data this cycle
shift_en  in  1  shift strobe; low = clock inhibit, register holds
ser_in  in  1  serial fill bit entering the vacated end
flush  in  1  synchronous abort: clear register, return to IDLE
ser_out  out  1  current output bit (LSB or MSB of register per LSB_FIRST)
ser_out_n  out  1  ~ser_out
busy  out  1  high in SHIFT state
done  out  1  one-cycle pulse, cycle after last bit retired
bit_cnt  out  CNT_W  number of bits shifted in current frame

Behaviour:
- Reset (rst_n low, async): shreg=0, state=IDLE, bit_cnt=0, done=0, busy=0, ser_out=0, ser_out_n=1.
- ser_out is taken directly from shreg, so it is effectively registered. ser_out_n is always its complement, in every state.
- States: IDLE, SHIFT.
- IDLE:
  - ld_ready=1 unless flush.
  - ld_valid&&ld_ready: shreg<=ld_data, bit_cnt<=0, ->SHIFT.
  - The first bit appears on ser_out the cycle after acceptance (latency 1).
  - shift_en is ignored; shreg holds.
- SHIFT:
  - shift_en=0: everything holds (inhibit).
  - shift_en=1:
    - LSB_FIRST=1: shreg<={ser_in, shreg[WIDTH-1:1]}.
    - LSB_FIRST=0: shreg<={shreg[WIDTH-2:0], ser_in}.
    - bit_cnt++.
- Frame end: in SHIFT with shift_en=1 and bit_cnt==WIDTH-1 (the WIDTH-th shift):
  - done<=1 next cycle.
  - ld_ready=1 combinationally in this cycle.
  - With ld_valid=1 the new word loads instead of the shift; state stays SHIFT and bit_cnt<=0. This gives back-to-back frames with no gap.
  - Otherwise the shift executes and state goes to IDLE. bit_cnt reads WIDTH in IDLE until the next load.
- ld_ready=0 in SHIFT at all other times; ld_valid is ignored there.
- flush (any state) takes priority over load and shift:
  - shreg<=0, bit_cnt<=0, ->IDLE.
  - done is not pulsed; ld_ready=0 that cycle.
- done is exactly one cycle wide per completed frame. It does not fire for flushed frames.
- Async reset mid-frame: immediate return to reset values; no done.
- ser_in is sampled only on shift cycles. After a full frame without reload, shreg holds the last WIDTH ser_in bits (cascade behaviour).

Decomposition:
- Package piso_pkg:
  - state enum {IDLE, SHIFT};
  - function clog2-based CNT_W helper.
- One natural sub-module: piso_shreg.
  - Parameters WIDTH, LSB_FIRST.
  - Inputs: load, shift, clear, d, ser_in.
  - Outputs: q_bit.
- Control FSM, counter and handshake stay in piso_shift_ctrl.

Test Plan:
1. WIDTH=8, LSB_FIRST=1, load 0xB4, shift_en=1 continuously -> ser_out 0,0,1,0,1,1,0,1 on 8 consecutive cycles, then done pulse once, busy falls, bit_cnt=8.
2. LSB_FIRST=0, load 0xB4 -> ser_out 1,0,1,1,0,1,0,0; ser_out_n is the complement on every cycle.
3. Load 0xFF, toggle shift_en 1,0,0,1,... -> ser_out and bit_cnt hold during inhibit cycles; done only after the 8th enabled shift.
4. Load 0x0F, then 0xF0 offered with ld_valid held high -> second word accepted exactly on the 8th shift cycle; 16 contiguous bits (LSB_FIRST=1): 1,1,1,1,0,0,0,0,0,0,0,0,1,1,1,1; two done pulses.
5. Load 0xAA, flush asserted together with ld_valid after 3 shifts -> IDLE next cycle, shreg=0, ser_out=0, no done, load not accepted.
6. ser_in=1 during the full frame of 0x00 -> after 8 shifts ser_out=1 in IDLE; rst_n dropped mid-frame -> outputs reach reset values without a clock edge.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out shifter.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Bit counter must be able to hold the value WIDTH itself (shown in IDLE after a frame).
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/piso_shreg.sv
// Shift register datapath: clear beats load, load beats shift; fill bit enters the vacated end.
module piso_shreg #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in,
    output logic             q_bit
);

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;

    always_comb begin
        // NOTE: default assignment first so every path assigns shreg_d and no latch is inferred.
        shreg_d = shreg_q;
        if (clear) begin
            shreg_d = '0;
        end else if (load) begin
            shreg_d = d;
        end else if (shift) begin
            shreg_d = LSB_FIRST ? {ser_in, shreg_q[WIDTH-1:1]}
                                : {shreg_q[WIDTH-2:0], ser_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments for all flop updates so every flop samples pre-edge values.
        if (!rst_n) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign q_bit = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];

endmodule

// File: rtl/piso_shift_ctrl.sv
// Load handshake, frame FSM and bit counter around the PISO shift register.
module piso_shift_ctrl
    import piso_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  bit LSB_FIRST = 1'b1,
    localparam int CNT_W     = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] ld_data,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic             shift_en,
    input  logic             ser_in,
    input  logic             flush,
    output logic             ser_out,
    output logic             ser_out_n,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] bit_cnt
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             frame_end;
    logic             ready_c;
    logic             do_load;
    logic             do_shift;

    always_comb begin
        frame_end = (state_q == SHIFT) && shift_en && (cnt_q == CNT_W'(WIDTH - 1));
        // Accepting on the last shift cycle lets frames run back to back without a gap.
        ready_c   = !flush && ((state_q == IDLE) || frame_end);
        do_load   = ld_valid && ready_c;
        do_shift  = !flush && !do_load && (state_q == SHIFT) && shift_en;

        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = frame_end && !flush;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (do_load) begin
            state_d = SHIFT;
            cnt_d   = '0;
        end else if (do_shift) begin
            cnt_d = cnt_q + 1'b1;
            if (frame_end) begin
                state_d = IDLE;
            end
        end
        busy_d = (state_d == SHIFT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    piso_shreg #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_shreg (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (do_load),
        .shift  (do_shift),
        .clear  (flush),
        .d      (ld_data),
        .ser_in (ser_in),
        .q_bit  (ser_out)
    );

    assign ser_out_n = ~ser_out;
    assign ld_ready  = ready_c;
    assign busy      = busy_q;
    assign done      = done_q;
    assign bit_cnt   = cnt_q;

endmodule
